demux_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the 4-way demux output path among four requesters. Arbitrates the request lines, drives the demux select and enable so that exactly one channel is routed at a time, and returns a one-hot grant to the winner. Sits directly in front of the 1-to-4 demux: its SEL/EN outputs connect to the demux S/E inputs.

---
 rtl/demux_sched_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 33 +++
 rtl/demux_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_demux_rr_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared definitions for the round-robin demux scheduler: FSM encoding,
// channel count and the channel-to-select / one-hot helpers.
package demux_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Demux wiring swaps the select bits relative to the channel index.
  function automatic logic [1:0] ch_to_sel(input logic [1:0] c);
    return {c[0], c[1]};
  endfunction

  function automatic logic [3:0] ch_onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches upward from last+1 with
// wrap-around and reports the first requesting channel.
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand[gi] = last + 2'(gi + 1);
    end
  endgenerate

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        valid = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler driving a 1-to-4 demux select/enable with a mandatory
// dead cycle between grants. Optional slot timeout: DEMUX_SCHED_SLOT_TIMEOUT_EN.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int SLOT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic [1:0] ch,
  output logic       busy
);

  generate
    if (SLOT_CYCLES < 1 || SLOT_CYCLES > 255) begin : g_slot_range_check
      $error("SLOT_CYCLES must be in 1..255");
    end
  endgenerate

  sched_state_t state_reg, state_next;
  logic [3:0]   gnt_reg, gnt_next;
  logic [1:0]   sel_reg, sel_next;
  logic         en_reg, en_next;
  logic [1:0]   ch_reg, ch_next;
  logic         busy_reg, busy_next;
  logic [1:0]   last_reg, last_next;

  logic         pick_valid;
  logic [1:0]   pick_idx;
  logic         slot_expired;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef DEMUX_SCHED_SLOT_TIMEOUT_EN
  logic [7:0] slot_cnt_reg, slot_cnt_next;

  // Counter holds 0 in the first grant cycle, so the last allowed cycle is SLOT_CYCLES-1.
  assign slot_expired = (slot_cnt_reg == 8'(SLOT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_cnt_reg <= 8'd0;
    else        slot_cnt_reg <= slot_cnt_next;
  end
`else
  assign slot_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'b00;
      en_reg    <= 1'b0;
      ch_reg    <= 2'd0;
      busy_reg  <= 1'b0;
      last_reg  <= 2'd3;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      en_reg    <= en_next;
      ch_reg    <= ch_next;
      busy_reg  <= busy_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    en_next    = en_reg;
    ch_next    = ch_reg;
    busy_next  = busy_reg;
    last_next  = last_reg;
`ifdef DEMUX_SCHED_SLOT_TIMEOUT_EN
    slot_cnt_next = slot_cnt_reg;
`endif

    case (state_reg)
      ST_GRANT: begin
        if (req[ch_reg] && !slot_expired) begin
`ifdef DEMUX_SCHED_SLOT_TIMEOUT_EN
          slot_cnt_next = slot_cnt_reg + 8'd1;
`endif
        end else begin
          // SEL and CH deliberately keep their values through the gap.
          state_next = ST_GAP;
          gnt_next   = 4'b0000;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end
      end

      default: begin
        if (pick_valid) begin
          state_next = ST_GRANT;
          gnt_next   = ch_onehot(pick_idx);
          sel_next   = ch_to_sel(pick_idx);
          en_next    = 1'b1;
          ch_next    = pick_idx;
          busy_next  = 1'b1;
          last_next  = pick_idx;
`ifdef DEMUX_SCHED_SLOT_TIMEOUT_EN
          slot_cnt_next = 8'd0;
`endif
        end else begin
          state_next = ST_IDLE;
          gnt_next   = 4'b0000;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end
      end
    endcase
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign en   = en_reg;
  assign ch   = ch_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with hand-computed expectations;
// the timeout scenario follows DEMUX_SCHED_SLOT_TIMEOUT_EN when defined.
module tb_demux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic [1:0] ch;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  demux_rr_scheduler #(.SLOT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .en    (en),
    .ch    (ch),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic [1:0] c);
    $display("txn %s: req=%b gnt=%b sel=%b ch=%0d en=%b busy=%b", tag, req, gnt, sel, ch, en, busy);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".ch"}, 32'(ch), 32'(c));
    check({tag, ".en"}, 32'(en), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic expect_off(input string tag, input logic [1:0] s);
    $display("txn %s: req=%b gnt=%b sel=%b ch=%0d en=%b busy=%b", tag, req, gnt, sel, ch, en, busy);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".en"}, 32'(en), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Structural invariants checked every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("en_vs_gnt", 32'(en), 32'(gnt != 4'b0000));
    end
  end

  logic [3:0] g_tab [4];
  logic [1:0] s_tab [4];

  initial begin
    g_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    s_tab = '{2'b00, 2'b10, 2'b01, 2'b11};
    rst_n = 1'b0;
    req   = 4'b0000;
    #7;
    expect_off("reset", 2'b00);
    check("reset.ch", 32'(ch), 32'd0);
    rst_n = 1'b1;

    // Single request on ch2, then release.
    req = 4'b0100;
    tick();
    expect_grant("single_ch2", 4'b0100, 2'b01, 2'd2);
    req = 4'b0000;
    tick();
    expect_off("single_gap", 2'b01);
    tick();
    expect_off("single_idle", 2'b01);

    // All four requesting from reset: order 0,1,2,3 with one gap between.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant($sformatf("rr%0d_c1", i), g_tab[i], s_tab[i], 2'(i));
      tick();
      expect_grant($sformatf("rr%0d_c2", i), g_tab[i], s_tab[i], 2'(i));
      req[i] = 1'b0;
      tick();
      expect_off($sformatf("rr%0d_gap", i), s_tab[i]);
    end
    tick();
    expect_off("rr_idle", 2'b11);

    // Wrap-around: last = 3, so ch0 wins, then ch3.
    req = 4'b1001;
    tick();
    expect_grant("wrap_ch0", 4'b0001, 2'b00, 2'd0);
    req = 4'b1000;
    tick();
    expect_off("wrap_gap", 2'b00);
    req = 4'b1001;
    tick();
    expect_grant("wrap_ch3", 4'b1000, 2'b11, 2'd3);
    req = 4'b0000;
    tick();
    expect_off("wrap_gap2", 2'b11);
    tick();

    // Slot timeout (or indefinite hold when the feature is absent).
    do_reset();
    req = 4'b0011;
`ifdef DEMUX_SCHED_SLOT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant($sformatf("slot_a%0d", i), 4'b0001, 2'b00, 2'd0);
    end
    tick();
    expect_off("slot_gap1", 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant($sformatf("slot_b%0d", i), 4'b0010, 2'b10, 2'd1);
    end
    tick();
    expect_off("slot_gap2", 2'b10);
    tick();
    expect_grant("slot_again", 4'b0001, 2'b00, 2'd0);
    req = 4'b0000;
    tick();
    expect_off("slot_end", 2'b00);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_grant($sformatf("hold%0d", i), 4'b0001, 2'b00, 2'd0);
    end
    req = 4'b0000;
    tick();
    expect_off("hold_end", 2'b00);
`endif
    tick();

    // Asynchronous reset mid-grant, then restart from ch0 priority.
    req = 4'b0100;
    tick();
    expect_grant("pre_rst_ch2", 4'b0100, 2'b01, 2'd2);
    rst_n = 1'b0;
    #1;
    check("async.gnt", 32'(gnt), 32'd0);
    check("async.en", 32'(en), 32'd0);
    check("async.busy", 32'(busy), 32'd0);
    check("async.sel", 32'(sel), 32'd0);
    req = 4'b0110;
    #1;
    rst_n = 1'b1;
    tick();
    expect_grant("post_rst_ch1", 4'b0010, 2'b10, 2'd1);
    req = 4'b0000;
    tick();
    tick();

    // Request on ch0 while ch2 holds: ignored until ch2 releases.
    do_reset();
    req = 4'b0100;
    tick();
    expect_grant("hold_ch2", 4'b0100, 2'b01, 2'd2);
    req = 4'b0101;
    tick();
    expect_grant("hold_ch2_req0", 4'b0100, 2'b01, 2'd2);
    req = 4'b0001;
    tick();
    expect_off("switch_gap", 2'b01);
    tick();
    expect_grant("switch_ch0", 4'b0001, 2'b00, 2'd0);
    req = 4'b0000;
    tick();
    expect_off("switch_end", 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
